// File: rtl/b2bcd_pkg.sv
// b2bcd_pkg: shared states, adjust constants and sizing helpers for the BCD converter
package b2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd4;
  localparam logic [3:0] ADJ_VAL = 4'd3;

  function automatic int bcd_digits(input int width);
    return (width + 2) / 3;
  endfunction

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/b2bcd_seq_ip_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit above 4
module bcd_digit_adj
  import b2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d > ADJ_THRESH) ? d + ADJ_VAL : d;

endmodule

// File: rtl/b2bcd_seq_ip.sv
// b2bcd_seq_ip: one-bit-per-clock binary-to-BCD converter with valid/ready handshake
module b2bcd_seq_ip
  import b2bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 3,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT*4-1:0] out_bcd,
  output logic               out_sign,
  output logic               out_ovf
);

  localparam int NI = bcd_digits(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;
  logic [NI*4-1:0] bcd, adj, fin;
  logic [WIDTH-1:0] sh, mag;
  logic [CW-1:0] cnt;
  logic [DIGIT*4-1:0] res;
  logic [NI-1:0] hi;
  logic neg, sign_r, accept, last;

  assign neg = (SIGNED != 0) && in_data[WIDTH-1];
  assign mag = neg ? -in_data : in_data;
  assign accept = (state == IDLE) && in_valid;
  assign last = (state == SHIFT) && (cnt == LAST);
  // Value the scratch register would hold after the final shift
  assign fin = {adj[NI*4-2:0], sh[WIDTH-1]};

  for (genvar g = 0; g < NI; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(bcd[g*4+:4]), .q(adj[g*4+:4]));
    if (g < DIGIT) begin : g_lo
      assign res[g*4+:4] = fin[g*4+:4];
      assign hi[g] = 1'b0;
    end else begin : g_hi
      assign hi[g] = |fin[g*4+:4];
    end
  end

  for (genvar g = NI; g < DIGIT; g++) begin : g_pad
    assign res[g*4+:4] = 4'd0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // Next-state: accept in IDLE, leave SHIFT on the WIDTH-th shift, retire in DONE
  always_comb begin
    state_n = accept ? SHIFT :
              last ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end

  // Scratch register, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd <= '0;
      sh <= '0;
      cnt <= '0;
      sign_r <= 1'b0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_bcd <= '0;
      out_sign <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      in_ready <= state_n == IDLE;
      if (accept) begin
        bcd <= '0;
        sh <= mag;
        cnt <= '0;
        sign_r <= neg;
      end
      if (state == SHIFT) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        out_valid <= 1'b1;
        out_bcd <= res;
        out_sign <= sign_r;
        out_ovf <= |hi;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b2bcd_seq_ip.sv
// tb_b2bcd_seq_ip: directed checks of four converter configurations
module tb_b2bcd_seq_ip;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] iv, ordy, ov, ir, sg, of;
  logic [7:0] d8;
  logic [15:0] d16;
  logic [11:0] b0, b2;
  logic [7:0] b1;
  logic [19:0] b3;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  b2bcd_seq_ip #(.WIDTH(8), .DIGIT(3), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d8),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_bcd(b0), .out_sign(sg[0]), .out_ovf(of[0]));
  b2bcd_seq_ip #(.WIDTH(8), .DIGIT(2), .SIGNED(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d8),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_bcd(b1), .out_sign(sg[1]), .out_ovf(of[1]));
  b2bcd_seq_ip #(.WIDTH(8), .DIGIT(3), .SIGNED(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d8),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_bcd(b2), .out_sign(sg[2]), .out_ovf(of[2]));
  b2bcd_seq_ip #(.WIDTH(16), .DIGIT(5), .SIGNED(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(d16),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_bcd(b3), .out_sign(sg[3]), .out_ovf(of[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] bcd_of(input int i);
    return i == 0 ? 20'(b0) : i == 1 ? 20'(b1) : i == 2 ? 20'(b2) : b3;
  endfunction

  task automatic conv(input int i, input logic [15:0] d, input logic [19:0] eb,
                      input logic es, input logic eo, input int el, input bit retire);
    int lat;
    if (i == 3) d16 = d;
    else d8 = d[7:0];
    chk($sformatf("rdy%0d_%0h", i, d), 32'(ir[i]), 32'd1);
    iv[i] = 1'b1;
    tick();
    iv[i] = 1'b0;
    lat = 0;
    while (!ov[i] && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("lat%0d_%0h", i, d), 32'(lat), 32'(el));
    chk($sformatf("bcd%0d_%0h", i, d), 32'(bcd_of(i)), 32'(eb));
    chk($sformatf("sign%0d_%0h", i, d), 32'(sg[i]), 32'(es));
    chk($sformatf("ovf%0d_%0h", i, d), 32'(of[i]), 32'(eo));
    if (retire) begin
      ordy[i] = 1'b1;
      tick();
      ordy[i] = 1'b0;
      chk($sformatf("retv%0d_%0h", i, d), 32'(ov[i]), 32'd0);
      chk($sformatf("retr%0d_%0h", i, d), 32'(ir[i]), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] vals [3];
    logic [19:0] exps [3];
    int acc, rcnt, cyc;
    int rt [3];
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    d8 = '0;
    d16 = '0;
    tick();
    tick();
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_bcd0", 32'(b0), 32'd0);
    chk("rst_bcd3", 32'(b3), 32'd0);
    chk("rst_sign", 32'(sg), 32'd0);
    chk("rst_ovf", 32'(of), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(ir), 32'hF);

    conv(0, 16'd255, 20'h255, 1'b0, 1'b0, 8, 1'b1);
    conv(1, 16'd255, 20'h55, 1'b0, 1'b1, 8, 1'b1);
    conv(1, 16'd99, 20'h99, 1'b0, 1'b0, 8, 1'b1);
    conv(1, 16'd100, 20'h00, 1'b0, 1'b1, 8, 1'b1);
    conv(2, 16'h80, 20'h128, 1'b1, 1'b0, 8, 1'b1);
    conv(2, 16'hFF, 20'h001, 1'b1, 1'b0, 8, 1'b1);
    conv(2, 16'h00, 20'h000, 1'b0, 1'b0, 8, 1'b1);
    conv(2, 16'h7F, 20'h127, 1'b0, 1'b0, 8, 1'b1);
    conv(0, 16'd0, 20'h000, 1'b0, 1'b0, 8, 1'b1);

    conv(0, 16'd123, 20'h123, 1'b0, 1'b0, 8, 1'b0);
    for (int k = 0; k < 5; k++) begin
      iv[0] = (k == 1);
      d8 = 8'd9;
      tick();
      chk($sformatf("bp_valid_%0d", k), 32'(ov[0]), 32'd1);
      chk($sformatf("bp_bcd_%0d", k), 32'(b0), 32'h123);
      chk($sformatf("bp_ready_%0d", k), 32'(ir[0]), 32'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("bp_ret_valid", 32'(ov[0]), 32'd0);
    chk("bp_ret_ready", 32'(ir[0]), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("bp_no_ghost", 32'(ov[0]), 32'd0);
    chk("bp_idle_ready", 32'(ir[0]), 32'd1);

    d8 = 8'd255;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_bcd", 32'(b0), 32'd0);
    chk("mid_rst_flags", 32'({sg[0], of[0]}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(ir[0]), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("mid_rst_no_result", 32'(ov[0]), 32'd0);
    conv(0, 16'd37, 20'h037, 1'b0, 1'b0, 8, 1'b1);

    conv(3, 16'hFFFF, 20'h65535, 1'b0, 1'b0, 16, 1'b1);

    vals[0] = 16'd0;
    vals[1] = 16'd1;
    vals[2] = 16'hFFFF;
    exps[0] = 20'h00000;
    exps[1] = 20'h00001;
    exps[2] = 20'h65535;
    acc = 0;
    rcnt = 0;
    cyc = 0;
    ordy[3] = 1'b1;
    while (rcnt < 3 && cyc < 200) begin
      if (ir[3] && acc < 3) begin
        d16 = vals[acc];
        iv[3] = 1'b1;
        acc++;
      end else iv[3] = 1'b0;
      tick();
      cyc++;
      if (ov[3]) begin
        chk($sformatf("b2b_bcd_%0d", rcnt), 32'(b3), 32'(exps[rcnt]));
        rt[rcnt] = cyc;
        rcnt++;
      end
    end
    iv[3] = 1'b0;
    ordy[3] = 1'b0;
    chk("b2b_count", 32'(rcnt), 32'd3);
    if (rcnt == 3) begin
      chk("b2b_ii_1", 32'(rt[1] - rt[0]), 32'd18);
      chk("b2b_ii_2", 32'(rt[2] - rt[1]), 32'd18);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/b2bcd_seq_ip.md
Name: b2bcd_seq_ip

Overview:
Multi-cycle, parametrised binary-to-BCD converter. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Successor to the combinational converter, generalised with:
  - an optional signed mode,
  - a valid/ready handshake on both sides,
  - overflow detection when DIGIT is too small for WIDTH.
- Sits between arithmetic datapaths and display/report logic where area matters more than latency.

Parameters:
WIDTH, 8, binary input width (>=4).
DIGIT, 3, number of BCD digits presented at the output (>=1).
SIGNED, 0, 1 = input is two's complement; magnitude is converted and the sign is reported separately.

Ports:
clk  in  1  sole clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  block can accept an input (high only in IDLE).
in_data  in  WIDTH  binary input.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  downstream accepts result.
out_bcd  out  DIGIT*4  BCD result; digit 0 in bits [3:0].
out_sign  out  1  1 = negative input (SIGNED=1 only; else tied 0).
out_ovf  out  1  1 = value >= 10^DIGIT; out_bcd then holds the low DIGIT digits.

Behaviour:
- Reset: rst_n sampled low at a clk edge drives the following outputs to 0 after that edge, and the state goes to IDLE:
  - out_valid, out_bcd, out_sign, out_ovf, all internal registers.
  - in_ready becomes 1 in the cycle after reset deasserts.
- Reset during SHIFT or DONE aborts the conversion. No result is produced.
- Internal digit count NI = ceil(WIDTH/3), which always covers 2^WIDTH-1. Scratch register is NI*4 BCD bits plus a WIDTH-bit shift field.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid at edge k:
    - load the shift field with the magnitude (SIGNED=1 and in_data[WIDTH-1]=1: two's-complement negate; else in_data);
    - clear BCD digits, count=0, latch sign -> SHIFT.
  - SHIFT: each edge:
    - every BCD digit >4 gets +3 (4-bit, no carry out);
    - the whole {BCD, shift} register shifts left by 1;
    - count+1.
    - On the edge where count reaches WIDTH-1 (the WIDTH-th shift), register the outputs, set out_valid=1 -> DONE.
    - in_ready=0; in_valid is ignored.
  - DONE: outputs are stable while out_valid=1. On out_ready=1 at an edge -> IDLE and out_valid=0.
- Latency: accept at edge k -> out_valid seen high after edge k+WIDTH. Minimum initiation interval WIDTH+2 cycles, since in_ready is 0 in the DONE cycle.
- out_ovf = OR of internal digits DIGIT..NI-1. If DIGIT>=NI: out_ovf=0 and the upper out_bcd digits are zero-filled.
- Signed edge case: -2^(WIDTH-1) has magnitude 2^(WIDTH-1). It fits the WIDTH-bit shift field unsigned and must convert correctly.
- Zero input: out_bcd=0, out_sign=0 (including SIGNED=1 with in_data=0).
- out_valid and out_ready both high with in_valid high: the result is retired this edge. The new input is accepted no earlier than the next edge (in IDLE).
- All outputs come from registers; no combinational path from inputs to outputs.

Decomposition:
- Package b2bcd_pkg:
  - state encoding (IDLE/SHIFT/DONE);
  - constant ADJ_THRESH=4 and ADJ_VAL=3;
  - function bcd_digits(width) returning ceil(width/3);
  - function cnt_width(width) returning the counter width.
- Sub-module bcd_digit_adj: combinational 4-bit "if >4 add 3". Instantiated NI times via generate.
- FSM, counter and shift register live in the top module.

Test Plan:
- WIDTH=8, DIGIT=3, SIGNED=0, in_data=8'd255 -> out_valid exactly 8 cycles after accept; out_bcd=12'h255, out_ovf=0.
- WIDTH=8, DIGIT=2, in_data=8'd255 -> out_bcd=8'h55, out_ovf=1. Also in_data=8'd99 -> 8'h99, out_ovf=0.
- WIDTH=8, DIGIT=3, SIGNED=1:
  - in_data=8'h80 -> out_bcd=12'h128, out_sign=1;
  - in_data=8'hFF -> 12'h001, sign=1;
  - in_data=8'h00 -> 12'h000, sign=0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_bcd/out_valid stable, in_ready=0, a pulsed in_valid is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: rst_n=0 at the 4th SHIFT edge of a 255 conversion -> all outputs 0 and in_ready=1 after release. The next input 8'd37 converts to 12'h037 with no residue.
- Wide config WIDTH=16, DIGIT=5: in_data=16'hFFFF -> out_bcd=20'h65535 after 16 cycles. Back-to-back inputs 0, 1, 65535 with out_ready=1 give results in order with an initiation interval of 18 cycles.
